pattern_pwm_decoder: RTL

Receive-side counterpart of the pattern PWM generator: samples a single PWM line, aligns to the first rising edge of a burst, and recovers the transmitted bit pattern plus the measured pulse high-width. Sits behind the pin/loopback path in the DDS/PWM subsystem, feeding captured frames to the control registers for self-test and external-signal analysis. One frame is `_PAT_WIDTH` consecutive bit slots of `slot_len` clocks each. A slot containing a pulse decodes as 1; an all-low slot decodes as 0.

---
 rtl/pattern_pwm_decoder_if.sv | 26 ++
 rtl/pattern_pwm_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pattern_pwm_decoder_if.sv
// Control, PWM line and capture-result bundle for pattern_pwm_decoder.
// master = controller/stimulus side, slave = decoder.
interface pattern_pwm_decoder_if #(
    parameter int _PAT_WIDTH  = 16,
    parameter int _SLOT_WIDTH = 16
);
    logic                   cap_en;
    logic [_SLOT_WIDTH-1:0] slot_len;
    logic                   pwm_in;
    logic [_PAT_WIDTH-1:0]  pat_out;
    logic [7:0]             duty_meas;
    logic [7:0]             frame_cnt;
    logic                   busy;
    logic                   valid;
    logic                   err;

    modport master (
        output cap_en, slot_len, pwm_in,
        input  pat_out, duty_meas, frame_cnt, busy, valid, err
    );

    modport slave (
        input  cap_en, slot_len, pwm_in,
        output pat_out, duty_meas, frame_cnt, busy, valid, err
    );
endinterface

// File: rtl/pattern_pwm_decoder.sv
// Recovers a slotted PWM bit pattern and slot-0 pulse width; optional PATTERN_PWM_DEC_GLITCH_FILTER_EN majority filter.
// Latency: valid 2+_PAT_WIDTH*len_q cycles after the pwm_in rise (+1 with the filter).
// No backpressure: valid is a one-cycle strobe and results hold until the next frame.
module pattern_pwm_decoder #(
    parameter int _PAT_WIDTH  = 16,
    parameter int _SLOT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pattern_pwm_decoder_if.slave bus
);
    localparam int IDX_W = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(_PAT_WIDTH - 1);
    localparam logic [IDX_W-1:0]       ONE_I    = IDX_W'(1);
    localparam logic [_SLOT_WIDTH-1:0] ONE_S    = _SLOT_WIDTH'(1);
    localparam logic [_SLOT_WIDTH-1:0] TWO_S    = _SLOT_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, ARM, SLOT, DONE} state_t;
    state_t state, state_nxt;

    logic sync1, s_in, s_in_d;
    logic line, line_d, rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            s_in   <= 1'b0;
            s_in_d <= 1'b0;
        end else begin
            sync1  <= bus.pwm_in;
            s_in   <= sync1;
            s_in_d <= s_in;
        end
    end

`ifdef PATTERN_PWM_DEC_GLITCH_FILTER_EN
    logic s_in_d2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_in_d2 <= 1'b0;
            line_d  <= 1'b0;
        end else begin
            s_in_d2 <= s_in_d;
            line_d  <= line;
        end
    end
    // 2-of-3 vote: a clean pulse keeps its width, just one cycle later
    assign line = (s_in & s_in_d) | (s_in & s_in_d2) | (s_in_d & s_in_d2);
`else
    assign line   = s_in;
    assign line_d = s_in_d;
`endif

    assign rise = line & ~line_d;

    logic [_SLOT_WIDTH-1:0] len_q, slot_ctr;
    logic [IDX_W-1:0]       slot_idx;
    logic [7:0]             hcnt, ref_duty;
    logic                   hit, err_sh;
    logic [_PAT_WIDTH-1:0]  pat_sh;

    logic [7:0]            hcnt_nxt, ref_cur;
    logic                  hit_nxt, slot_last, frame_last, slot_err, len_bad;
    logic                  start, abort, fin;
    logic [_PAT_WIDTH-1:0] pat_nxt;

    always_comb begin
        hcnt_nxt   = (hcnt == 8'hFF) ? hcnt : hcnt + {7'd0, line};
        hit_nxt    = hit | line;
        slot_last  = (slot_ctr == len_q - ONE_S);
        frame_last = slot_last && (slot_idx == LAST_IDX);
        ref_cur    = (slot_idx == '0) ? hcnt_nxt : ref_duty;
        // width mismatch on a 1-slot, or a pulse still high at the slot boundary
        slot_err   = line | (hit_nxt && (hcnt_nxt != ref_cur));
        pat_nxt    = pat_sh;
        pat_nxt[slot_idx] = hit_nxt;
        len_bad    = (bus.slot_len < TWO_S);
        start      = (state == ARM) && bus.cap_en && rise && !len_bad;
        abort      = (state == ARM) && bus.cap_en && rise && len_bad;
        fin        = (state == SLOT) && bus.cap_en && frame_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.cap_en) state_nxt = ARM;
            ARM: begin
                if (!bus.cap_en) state_nxt = IDLE;
                else if (rise)   state_nxt = len_bad ? DONE : SLOT;
            end
            SLOT: begin
                if (!bus.cap_en)     state_nxt = IDLE;
                else if (frame_last) state_nxt = DONE;
            end
            DONE:    state_nxt = bus.cap_en ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame shadow state; the rise cycle itself is sample 0 of slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            slot_ctr <= '0;
            slot_idx <= '0;
            hcnt     <= '0;
            hit      <= 1'b0;
            ref_duty <= '0;
            err_sh   <= 1'b0;
            pat_sh   <= '0;
        end else if (start || abort) begin
            len_q    <= bus.slot_len;
            slot_ctr <= ONE_S;
            slot_idx <= '0;
            hcnt     <= 8'd1;
            hit      <= 1'b1;
            err_sh   <= 1'b0;
        end else if (state == SLOT) begin
            if (slot_last) begin
                slot_ctr <= '0;
                slot_idx <= slot_idx + ONE_I;
                hcnt     <= '0;
                hit      <= 1'b0;
                pat_sh   <= pat_nxt;
                if (slot_idx == '0) ref_duty <= hcnt_nxt;
                if (slot_err)       err_sh   <= 1'b1;
            end else begin
                slot_ctr <= slot_ctr + ONE_S;
                hcnt     <= hcnt_nxt;
                hit      <= hit_nxt;
            end
        end
    end

    logic [_PAT_WIDTH-1:0] pat_q;
    logic [7:0]            duty_q, fcnt_q;
    logic                  valid_q, err_q, cap_en_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q    <= '0;
            duty_q   <= '0;
            fcnt_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cap_en_d <= 1'b0;
        end else begin
            cap_en_d <= bus.cap_en;
            valid_q  <= abort | fin;
            if (abort) begin
                err_q  <= 1'b1;
                fcnt_q <= fcnt_q + 8'd1;
            end else if (fin) begin
                pat_q  <= pat_nxt;
                duty_q <= ref_cur;
                err_q  <= err_sh | slot_err;
                fcnt_q <= fcnt_q + 8'd1;
            end
            if (bus.cap_en && !cap_en_d) fcnt_q <= '0;
        end
    end

    assign bus.pat_out   = pat_q;
    assign bus.duty_meas = duty_q;
    assign bus.frame_cnt = fcnt_q;
    assign bus.valid     = valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state == ARM) || (state == SLOT);
endmodule
